// File: rtl/song_reader_pkg.sv
// Shared song-word definitions for the song reader, note arranger and ROM builder.
// Holds the reader state encoding, the word field positions and the end-marker test.
package song_pkg;

  localparam int WORD_BITS    = 16;
  localparam int ADV_FLAG_BIT = 15;
  localparam int NOTE_MSB     = 14;
  localparam int NOTE_LSB     = 9;
  localparam int DUR_MSB      = 8;
  localparam int DUR_LSB      = 3;
  localparam int STEREO_MSB   = 2;
  localparam int STEREO_LSB   = 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_WAIT_ROM  = 3'd2;
  localparam logic [2:0] ST_PRESENT   = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_FETCH     = ST_FETCH,
    S_WAIT_ROM  = ST_WAIT_ROM,
    S_PRESENT   = ST_PRESENT,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_DONE      = ST_DONE
  } reader_state_t;

  // An advance word with zero beats terminates the song.
  function automatic logic is_end_marker(input logic [WORD_BITS-1:0] word);
    return word[ADV_FLAG_BIT] && (word[DUR_MSB:DUR_LSB] == '0);
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// Control and ROM bus between the song reader (slave modport) and its environment
// (master modport: player controls, arranger handshake and the song ROM).
interface song_reader_if #(
  parameter int ADDR_BITS = 5,
  parameter int SONG_BITS = 2
);
  logic                           play;
  logic [SONG_BITS-1:0]           song;
  logic                           new_song;
  logic                           note_done;
  logic [SONG_BITS+ADDR_BITS-1:0] rom_addr;
  logic [15:0]                    rom_data;
  logic [15:0]                    note_to_load;
  logic                           load_new_note;
  logic                           song_done;

  modport master (
    output play, song, new_song, note_done, rom_data,
    input  rom_addr, note_to_load, load_new_note, song_done
  );

  modport slave (
    input  play, song, new_song, note_done, rom_data,
    output rom_addr, note_to_load, load_new_note, song_done
  );
endinterface

// File: rtl/song_reader_addr_counter.sv
// Word address counter for one song: clear has priority over increment, and
// o_wrap pulses combinationally on the increment that rolls over to zero.
module song_addr_counter #(
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_clr,
  input  logic                 i_inc,
  output logic [ADDR_BITS-1:0] o_count,
  output logic                 o_wrap
);

  logic [ADDR_BITS-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_wrap  = i_inc && !i_clr && (r_count == {ADDR_BITS{1'b1}});

endmodule

// File: rtl/song_reader.sv
// Walks a song in synchronous ROM and hands each note word to the arranger.
// Define SONG_READER_LOOP_SONG_EN to repeat the song instead of stopping at its end.
module song_reader
  import song_pkg::*;
#(
  parameter int ADDR_BITS = 5,
  parameter int SONG_BITS = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  song_reader_if.slave bus
);

  reader_state_t        r_state;
  logic [SONG_BITS-1:0] r_song_q;
  logic [15:0]          r_note_to_load;
  logic                 r_load_new_note;
  logic                 r_song_done;

  logic [ADDR_BITS-1:0] w_word_addr;
  logic                 w_wrap;
  logic                 w_inc;
  logic                 w_clr;
  logic                 w_loop_clr;
  logic                 w_end_marker;

  assign w_end_marker = is_end_marker(bus.rom_data);
  assign w_inc        = (r_state == S_WAIT_DONE) && bus.note_done && !bus.new_song;

`ifdef SONG_READER_LOOP_SONG_EN
  // A mid-song end marker rewinds; a wrap returns to zero on its own.
  assign w_loop_clr = (r_state == S_WAIT_ROM) && w_end_marker && (w_word_addr != '0);
`else
  assign w_loop_clr = 1'b0;
`endif

  assign w_clr = bus.new_song || w_loop_clr;

  song_addr_counter #(.ADDR_BITS(ADDR_BITS)) u_addr_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_count (w_word_addr),
    .o_wrap  (w_wrap)
  );

  // Pulses default low so each one lasts exactly one cycle; new_song overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_song_q        <= '0;
      r_note_to_load  <= 16'h0000;
      r_load_new_note <= 1'b0;
      r_song_done     <= 1'b0;
    end else begin
      r_load_new_note <= 1'b0;
      r_song_done     <= 1'b0;
      if (bus.new_song) begin
        r_song_q <= bus.song;
        r_state  <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.play) r_state <= S_FETCH;
          end
          S_FETCH: begin
            r_state <= bus.play ? S_WAIT_ROM : S_IDLE;
          end
          S_WAIT_ROM: begin
            r_note_to_load <= bus.rom_data;
            if (w_end_marker) begin
              r_song_done <= 1'b1;
`ifdef SONG_READER_LOOP_SONG_EN
              r_state     <= (w_word_addr != '0) ? S_FETCH : S_DONE;
`else
              r_state     <= S_DONE;
`endif
            end else begin
              r_load_new_note <= 1'b1;
              r_state         <= S_PRESENT;
            end
          end
          S_PRESENT: begin
            r_state <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (bus.note_done) begin
              if (w_wrap) begin
                r_song_done <= 1'b1;
`ifdef SONG_READER_LOOP_SONG_EN
                r_state     <= S_FETCH;
`else
                r_state     <= S_DONE;
`endif
              end else begin
                r_state <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            r_state <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rom_addr      = {r_song_q, w_word_addr};
  assign bus.note_to_load  = r_note_to_load;
  assign bus.load_new_note = r_load_new_note;
  assign bus.song_done     = r_song_done;

endmodule

// File: tb/tb_song_reader.sv
// Directed self-checking bench for song_reader with a behavioural ROM and arranger.
// Build with SONG_READER_LOOP_SONG_EN defined to exercise the looping variant.
module tb_song_reader;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  song_reader_if #(.ADDR_BITS(5), .SONG_BITS(2)) bus ();

  song_reader #(.ADDR_BITS(5), .SONG_BITS(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [15:0] rom [0:127];
  int checks = 0;
  int errors = 0;
  int loadCount = 0;
  int doneCount = 0;
  int overlapCount = 0;
  int base;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Pulse bookkeeping sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.load_new_note === 1'b1) loadCount++;
    if (bus.song_done === 1'b1) doneCount++;
    if (bus.load_new_note === 1'b1 && bus.song_done === 1'b1) overlapCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic ns, input logic [1:0] s, input logic nd);
    bus.play      = p;
    bus.new_song  = ns;
    bus.song      = s;
    bus.note_done = nd;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitLoad(input string tag);
    bit seen;
    seen = (bus.load_new_note === 1'b1);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.load_new_note === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, " load timeout"}, 32'd0, 32'd1);
  endtask

  task automatic waitSongDone(input string tag);
    bit seen;
    seen = (bus.song_done === 1'b1);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.song_done === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput({tag, " song_done timeout"}, 32'd0, 32'd1);
  endtask

  // Arranger answers three cycles after the load pulse.
  task automatic returnDone();
    tick(2);
    bus.note_done = 1'b1;
    @(negedge clk);
    bus.note_done = 1'b0;
  endtask

  task automatic pulseNewSong(input logic [1:0] s);
    @(negedge clk);
    bus.new_song = 1'b1;
    bus.song     = s;
    @(negedge clk);
    bus.new_song = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1234;
    rom[1] = 16'h8040;
    rom[2] = 16'h8000;
    for (int i = 0; i < 32; i++) rom[32 + i] = 16'((i << 9) | 16'h001C);
`ifdef SONG_READER_LOOP_SONG_EN
    rom[64] = 16'h8000;
    rom[96] = 16'h0208;
    rom[97] = 16'h0410;
    rom[98] = 16'h8000;
`else
    rom[64] = 16'h2A18;
    rom[65] = 16'h0C30;
`endif

    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    #1;
    checkOutput("reset load", 32'(bus.load_new_note), 32'd0);
    checkOutput("reset song_done", 32'(bus.song_done), 32'd0);
    checkOutput("reset note", 32'(bus.note_to_load), 32'h0000);
    checkOutput("reset addr", 32'(bus.rom_addr), 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    tick(3);
    #1;
    checkOutput("idle no load", 32'(loadCount), 32'd0);

`ifdef SONG_READER_LOOP_SONG_EN
    bus.play = 1'b1;
    pulseNewSong(2'd3);
    for (int rep = 0; rep < 2; rep++) begin
      waitLoad("loop w0");
      checkOutput("loop w0 note", 32'(bus.note_to_load), 32'h0208);
      checkOutput("loop w0 addr", 32'(bus.rom_addr), 32'h60);
      returnDone();
      waitLoad("loop w1");
      checkOutput("loop w1 note", 32'(bus.note_to_load), 32'h0410);
      checkOutput("loop w1 addr", 32'(bus.rom_addr), 32'h61);
      returnDone();
      #1 base = doneCount;
      waitSongDone("loop end");
      checkOutput("loop rewind addr", 32'(bus.rom_addr), 32'h60);
    end
    pulseNewSong(2'd2);
    #1 base = loadCount;
    waitSongDone("empty song");
    tick(8);
    #1;
    checkOutput("empty song no load", 32'(loadCount), 32'(base));
    checkOutput("empty song held", 32'(bus.rom_addr), 32'h40);
    checkOutput("empty song done low", 32'(bus.song_done), 32'd0);
`else
    // Song 0: note, advance, end marker.
    bus.play = 1'b1;
    waitLoad("s0 w0");
    checkOutput("s0 w0 note", 32'(bus.note_to_load), 32'h1234);
    checkOutput("s0 w0 addr", 32'(bus.rom_addr), 32'h00);
    returnDone();
    waitLoad("s0 w1");
    checkOutput("s0 w1 note", 32'(bus.note_to_load), 32'h8040);
    checkOutput("s0 w1 addr", 32'(bus.rom_addr), 32'h01);
    returnDone();
    waitSongDone("s0 end");
    checkOutput("s0 end addr", 32'(bus.rom_addr), 32'h02);
    tick(5);
    #1;
    checkOutput("s0 load count", 32'(loadCount), 32'd2);
    checkOutput("s0 done count", 32'(doneCount), 32'd1);
    checkOutput("s0 held addr", 32'(bus.rom_addr), 32'h02);

    // Pause during FETCH of word 1.
    pulseNewSong(2'd0);
    waitLoad("pause w0");
    returnDone();
    bus.play = 1'b0;
    #1 base = loadCount;
    tick(10);
    #1;
    checkOutput("pause no load", 32'(loadCount), 32'(base));
    checkOutput("pause addr", 32'(bus.rom_addr), 32'h01);
    bus.play = 1'b1;
    waitLoad("resume");
    checkOutput("resume note", 32'(bus.note_to_load), 32'h8040);
    checkOutput("resume addr", 32'(bus.rom_addr), 32'h01);
    returnDone();
    waitSongDone("pause end");

    // Song 1: full 32 words, completion by address wrap.
    pulseNewSong(2'd1);
    #1 base = loadCount;
    for (int i = 0; i < 32; i++) begin
      waitLoad("s1 word");
      checkOutput("s1 note", 32'(bus.note_to_load), 32'((i << 9) | 32'h1C));
      checkOutput("s1 addr", 32'(bus.rom_addr), 32'(32 + i));
      returnDone();
    end
    waitSongDone("s1 wrap");
    tick(6);
    #1;
    checkOutput("s1 load count", 32'(loadCount - base), 32'd32);
    checkOutput("s1 wrapped addr", 32'(bus.rom_addr), 32'h20);

    // new_song collides with note_done in WAIT_DONE.
    pulseNewSong(2'd1);
    waitLoad("s1 restart");
    checkOutput("s1 restart note", 32'(bus.note_to_load), 32'h001C);
    tick(2);
    #1 base = loadCount;
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0);
    checkOutput("collide addr", 32'(bus.rom_addr), 32'h40);
    checkOutput("collide no done", 32'(bus.song_done), 32'd0);
    waitLoad("s2 w0");
    checkOutput("s2 w0 note", 32'(bus.note_to_load), 32'h2A18);
    checkOutput("s2 w0 addr", 32'(bus.rom_addr), 32'h40);
    #1;
    checkOutput("collide one load", 32'(loadCount - base), 32'd1);

    // Asynchronous reset while load_new_note is high.
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async load", 32'(bus.load_new_note), 32'd0);
    checkOutput("async note", 32'(bus.note_to_load), 32'h0000);
    checkOutput("async song_done", 32'(bus.song_done), 32'd0);
    checkOutput("async addr", 32'(bus.rom_addr), 32'h00);
    bus.play = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1 base = loadCount;
    tick(5);
    #1;
    checkOutput("post reset idle", 32'(loadCount), 32'(base));
    bus.play = 1'b1;
    waitLoad("post reset");
    checkOutput("post reset note", 32'(bus.note_to_load), 32'h1234);
    checkOutput("post reset addr", 32'(bus.rom_addr), 32'h00);
`endif

    #1;
    checkOutput("pulse overlap", 32'(overlapCount), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
